spi_slave: RTL
==============

# spi_slave

SPI slave front end that drives the single-port RAM's write/command channel and consumes its read channel. It deserialises MOSI frames into 10-bit command words (`rx_data`/`rx_valid`) for the RAM. It serialises the RAM's 8-bit read data (`tx_data`/`tx_valid`) back onto MISO. Together with the RAM it forms the top-level SPI-slave-with-memory wrapper.

## Interface
Parameters:
- `RX_W`, 10: width of command word to RAM (2 command bits + 8 payload).
- `TX_W`, 8: width of read data from RAM.

Ports:
- `clk`  in  1  SPI clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low; high ends/aborts a frame.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.
- `rx_data`  out  RX_W  command word to RAM; `[9:8]`: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  in  TX_W  read data from RAM.
- `tx_valid`  in  1  `tx_data` valid strobe from RAM.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `SS_n`=0 sampled -> CHK_CMD.
- CHK_CMD: samples MOSI as mode bit (not stored).
  - 0 -> WRITE.
  - 1 -> READ_ADD if `rd_addr_done`=0, else READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift 10 MOSI bits MSB first; 4-bit bit counter 0..9.
- After 10th bit: `rx_data` <= shift register, `rx_valid`=1 for exactly one cycle. Slave does not check `[9:8]` against the mode bit.
- `rd_addr_done`:
  - Set when a READ_ADD frame completes.
  - Cleared when a READ_DATA frame finishes its MISO shift, or on abort of READ_DATA after `rx_valid`.
- READ_DATA after `rx_valid`:
  - Wait for `tx_valid`; latch `tx_data`.
  - Drive 8 bits on MISO, MSB first.
  - Then hold MISO=0 and ignore MOSI until `SS_n`=1.
- `tx_valid` outside the READ_DATA wait phase is ignored.
- WRITE/READ_ADD after `rx_valid`: ignore MOSI until `SS_n`=1.
- `SS_n`=1 in any state -> IDLE next cycle; bit counter cleared.
  - A partial frame produces no `rx_valid`.
  - An in-progress MISO shift is abandoned; MISO=0.
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, state IDLE, `rd_addr_done`=0, counters 0.

## Timing
- Cycle n: `SS_n` low sampled in IDLE. Cycle n+1: mode bit sampled. Cycles n+2..n+11: payload bits.
- `rx_valid` high in cycle n+12 (registered, one cycle after the 10th bit).
- MISO latency: `tx_valid` sampled at cycle m -> MISO carries bit7 during cycle m+1, through bit0 during cycle m+8.
- `tx_valid` coincident with the `rx_valid` cycle is accepted.
- `SS_n` rising in the same cycle as the 10th bit: bit is discarded and no `rx_valid` (`SS_n` high has priority).
- Async reset mid-frame: all outputs go to reset values immediately, with no clock edge required.

## Configuration
- `SPI_SLAVE_SVA_EN` defined: embedded concurrent assertions compiled in.
  - `rx_valid` is never high two consecutive cycles.
  - `rx_valid` only follows exactly 10 payload bits with `SS_n` low.
  - MISO=0 outside the shift window.
  - All outputs are at reset values while `rst_n`=0.
  - Matching cover properties for every state transition.
- Undefined: no assertion code; RTL behaviour identical.

## Structure
- `spi_slave_pkg`:
  - State enum `spi_state_e`.
  - Command constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
  - `RX_W`/`TX_W` defaults.
- One sub-module, `spi_slave_piso`: 8-bit load-on-`tx_valid` parallel-in/serial-out with a 3-bit counter and abort input. The FSM and receive shifter stay in the top.

## Test plan
- Write address: `SS_n` low, mode 0, bits 00_1010_0101 -> `rx_valid` one cycle with `rx_data`=10'h0A5, MISO stays 0.
- Read sequence:
  - Mode 1, bits 10_0000_0011 -> `rx_data`=10'h203, `rd_addr_done`=1.
  - New frame, mode 1, bits 11_xxxx_xxxx -> `rx_valid`.
  - `tx_valid` with `tx_data`=8'h3C -> MISO 0,0,1,1,1,1,0,0 over the next 8 cycles.
  - `rd_addr_done` returns to 0.
- Read-data frame without a prior read-address -> FSM enters READ_ADD; a frame with `[9:8]`=11 still produces `rx_valid`; no MISO output without `tx_valid`.
- Abort: `SS_n` high after 6 payload bits -> no `rx_valid`; the next full write frame decodes correctly.
- Reset mid-MISO shift: `rst_n` low after 3 bits -> MISO=0, state IDLE, `rd_addr_done`=0 immediately.
- Ignored strobe: `tx_valid` in WRITE or IDLE -> MISO stays 0, no state change.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
// Assertions in spi_slave are enabled by defining SPI_SLAVE_SVA_EN.
package spi_slave_pkg;

  localparam int unsigned DEF_RX_W  = 10;
  localparam int unsigned DEF_TX_W  = 8;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Command word as presented to the RAM.
  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] payload;
  } rx_word_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM command/read channels seen by the SPI slave.
interface spi_slave_if #(
  parameter int unsigned RX_W = spi_slave_pkg::DEF_RX_W,
  parameter int unsigned TX_W = spi_slave_pkg::DEF_TX_W
);

  logic            SS_n;
  logic            MOSI;
  logic            MISO;
  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_slave_piso.sv
// Parallel-in/serial-out for RAM read data: loads on a strobe, shifts MSB first,
// returns to 0 when finished or aborted.
module spi_slave_piso #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         abort,
  input  logic [W-1:0] data,
  output logic         miso,
  output logic         busy,
  output logic         done_c
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-2:0] sh;
  logic [CW-1:0] cnt;

  assign done_c = busy && (cnt == LAST) && !abort;

  // MSB goes out on the load edge; remaining bits hold in sh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      miso <= 1'b0;
      busy <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      miso <= 1'b0;
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        miso <= 1'b0;
        busy <= 1'b0;
      end else begin
        cnt  <= cnt + CW'(1);
        miso <= sh[W-2];
        sh   <= {sh[W-3:0], 1'b0};
      end
    end else if (load) begin
      sh   <= data[W-2:0];
      cnt  <= '0;
      miso <= data[W-1];
      busy <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM: MOSI frames -> command words,
// RAM read data -> MISO. Define SPI_SLAVE_SVA_EN to compile embedded assertions.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned RX_W = DEF_RX_W,
  parameter int unsigned TX_W = DEF_TX_W
) (
  input logic       clk,
  input logic       rst_n,
  spi_slave_if.slave bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(RX_W - 1);

  spi_state_e state, state_nxt;

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [RX_W-2:0]      shift_q;
  logic                 frame_done;
  logic                 rd_addr_done;
  logic                 tx_taken;
  logic                 shift_en_c;
  logic                 last_bit_c;
  logic                 tx_load_c;
  logic                 piso_busy;
  logic                 piso_done_c;
  logic                 miso_bit;

  assign shift_en_c = (state inside {WRITE, READ_ADD, READ_DATA}) && !frame_done && !bus.SS_n;
  assign last_bit_c = shift_en_c && (bit_cnt == LAST_BIT);
  // Read data is accepted once per READ_DATA frame, from the rx_valid cycle on.
  assign tx_load_c  = (state == READ_DATA) && frame_done && !tx_taken && !piso_busy
                      && !bus.SS_n && bus.tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: state_nxt = bus.MOSI ? (rd_addr_done ? READ_DATA : READ_ADD) : WRITE;
        default: state_nxt = state;
      endcase
    end
  end

  // Receive shifter, frame bookkeeping and read-address tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift_q      <= '0;
      frame_done   <= 1'b0;
      tx_taken     <= 1'b0;
      rd_addr_done <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= last_bit_c;
      if (bus.SS_n) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        tx_taken   <= 1'b0;
      end else if (shift_en_c) begin
        shift_q <= {shift_q[RX_W-3:0], bus.MOSI};
        if (last_bit_c) begin
          bus.rx_data <= {shift_q, bus.MOSI};
          frame_done  <= 1'b1;
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end
      if (tx_load_c) tx_taken <= 1'b1;
      if (last_bit_c && (state == READ_ADD)) begin
        rd_addr_done <= 1'b1;
      end else if (piso_done_c || (bus.SS_n && (state == READ_DATA) && frame_done)) begin
        rd_addr_done <= 1'b0;
      end
    end
  end

  spi_slave_piso #(.W(TX_W)) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tx_load_c),
    .abort  (bus.SS_n),
    .data   (bus.tx_data),
    .miso   (miso_bit),
    .busy   (piso_busy),
    .done_c (piso_done_c)
  );

  assign bus.MISO = miso_bit;

`ifdef SPI_SLAVE_SVA_EN
  a_rx_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    bus.rx_valid |=> !bus.rx_valid);
  a_rx_src: assert property (@(posedge clk) disable iff (!rst_n)
    bus.rx_valid |-> $past(last_bit_c));
  a_miso_win: assert property (@(posedge clk) disable iff (!rst_n)
    !piso_busy |-> !bus.MISO);
  a_rst_vals: assert property (@(posedge clk)
    !rst_n |-> (!bus.MISO && !bus.rx_valid && (bus.rx_data == '0)));

  c_idle_chk:    cover property (@(posedge clk) state == IDLE      ##1 state == CHK_CMD);
  c_chk_idle:    cover property (@(posedge clk) state == CHK_CMD   ##1 state == IDLE);
  c_chk_wr:      cover property (@(posedge clk) state == CHK_CMD   ##1 state == WRITE);
  c_chk_ra:      cover property (@(posedge clk) state == CHK_CMD   ##1 state == READ_ADD);
  c_chk_rd:      cover property (@(posedge clk) state == CHK_CMD   ##1 state == READ_DATA);
  c_wr_idle:     cover property (@(posedge clk) state == WRITE     ##1 state == IDLE);
  c_ra_idle:     cover property (@(posedge clk) state == READ_ADD  ##1 state == IDLE);
  c_rd_idle:     cover property (@(posedge clk) state == READ_DATA ##1 state == IDLE);
`endif

endmodule
